// File: rtl/exe_mem_stage_reg.sv
// rtl/exe_mem_stage_reg.sv - EXE/MEM pipeline register with architectural NZCV status register
module exe_mem_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  s_in,
    input  logic [DATA_W-1:0]     alu_res_in,
    input  logic [3:0]            status_in,
    input  logic [DATA_W-1:0]     val_rm_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [DATA_W-1:0]     pc_in,
    output logic                  wb_en,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    output logic [DATA_W-1:0]     alu_res,
    output logic [DATA_W-1:0]     val_rm,
    output logic [REG_ADDR_W-1:0] dest,
    output logic [DATA_W-1:0]     pc,
    output logic [3:0]            status_reg,
    output logic                  carry_out
);

    // Priority: rst > freeze > flush > normal load. A flush seen only under freeze is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en      <= 1'b0;
            mem_r_en   <= 1'b0;
            mem_w_en   <= 1'b0;
            alu_res    <= '0;
            val_rm     <= '0;
            dest       <= '0;
            pc         <= '0;
            status_reg <= 4'b0000;
        end else if (!freeze) begin
            if (flush) begin
                // Bubble: null instruction, flags untouched since its S bit never reaches here
                wb_en    <= 1'b0;
                mem_r_en <= 1'b0;
                mem_w_en <= 1'b0;
                alu_res  <= '0;
                val_rm   <= '0;
                dest     <= '0;
                pc       <= '0;
            end else begin
                wb_en    <= wb_en_in;
                mem_r_en <= mem_r_en_in;
                mem_w_en <= mem_w_en_in;
                alu_res  <= alu_res_in;
                val_rm   <= val_rm_in;
                dest     <= dest_in;
                pc       <= pc_in;
                if (s_in) begin
                    status_reg <= status_in;
                end
            end
        end
    end

    // Combinational so an ADC/SBC right behind an S-setting op sees the fresh carry
    assign carry_out = status_reg[1];

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// tb/tb_exe_mem_stage_reg.sv - scoreboard bench for exe_mem_stage_reg with directed vectors
module tb_exe_mem_stage_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, s_in;
    logic [31:0] alu_res_in, val_rm_in, pc_in;
    logic [3:0]  status_in, dest_in;
    logic        wb_en, mem_r_en, mem_w_en, carry_out;
    logic [31:0] alu_res, val_rm, pc;
    logic [3:0]  dest, status_reg;

    exe_mem_stage_reg #(.DATA_W(32), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .s_in(s_in), .alu_res_in(alu_res_in), .status_in(status_in),
        .val_rm_in(val_rm_in), .dest_in(dest_in), .pc_in(pc_in),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_res(alu_res), .val_rm(val_rm), .dest(dest), .pc(pc),
        .status_reg(status_reg), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        string       name;
        logic        wb, mr, mw, cy;
        logic [31:0] alu, vrm, pcv;
        logic [3:0]  dst, st;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: the register presents a result every cycle; check the one due now
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation for cycle %0d never checked", exp_q[0].name, exp_q[0].tag);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (wb_en !== e.wb || mem_r_en !== e.mr || mem_w_en !== e.mw ||
                alu_res !== e.alu || val_rm !== e.vrm || dest !== e.dst ||
                pc !== e.pcv || status_reg !== e.st || carry_out !== e.cy) begin
                n_bad++;
                $display("FAIL %s: got wb=%b mr=%b mw=%b alu=%h vrm=%h dest=%h pc=%h st=%b cy=%b, want wb=%b mr=%b mw=%b alu=%h vrm=%h dest=%h pc=%h st=%b cy=%b",
                         e.name, wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest, pc, status_reg, carry_out,
                         e.wb, e.mr, e.mw, e.alu, e.vrm, e.dst, e.pcv, e.st, e.cy);
            end
            if (mem_r_en === 1'b1 && mem_w_en === 1'b1)
                $display("note: %s has illegal load+store pair captured", e.name);
        end
    end

    // Drive one cycle of inputs and queue the hand-computed result for the next edge
    task automatic step(input string nm,
                        input logic r, fz, fl, wb, mr, mw, s,
                        input logic [31:0] alu, input logic [3:0] st,
                        input logic [31:0] vrm, input logic [3:0] dst, input logic [31:0] pcv,
                        input logic e_wb, e_mr, e_mw,
                        input logic [31:0] e_alu, e_vrm, input logic [3:0] e_dst,
                        input logic [31:0] e_pc, input logic [3:0] e_st, input logic e_cy);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; freeze = fz; flush = fl;
        wb_en_in = wb; mem_r_en_in = mr; mem_w_en_in = mw; s_in = s;
        alu_res_in = alu; status_in = st; val_rm_in = vrm; dest_in = dst; pc_in = pcv;
        e.tag = cyc + 1; e.name = nm;
        e.wb = e_wb; e.mr = e_mr; e.mw = e_mw; e.alu = e_alu; e.vrm = e_vrm;
        e.dst = e_dst; e.pcv = e_pc; e.st = e_st; e.cy = e_cy;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b1; flush = 1'b0;
        wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; s_in = 1'b0;
        alu_res_in = '0; status_in = '0; val_rm_in = '0; dest_in = '0; pc_in = '0;

        //    name         rst fz fl wb mr mw s  alu_in        st_in    vrm_in        dst   pc_in          wb mr mw alu           vrm           dst   pc            st       cy
        step("reset0",     1, 1, 0, 1, 1, 0, 1, 32'hAAAA5555, 4'b1111, 32'h12345678, 4'hF, 32'h00000100,  0, 0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        4'b0000, 0);
        step("reset1",     1, 1, 0, 1, 0, 1, 1, 32'h5555AAAA, 4'b1111, 32'h87654321, 4'hE, 32'h00000104,  0, 0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        4'b0000, 0);
        step("add_neg",    0, 0, 0, 1, 0, 0, 1, 32'hFFFFFFF5, 4'b1000, 32'h0,        4'h3, 32'h00000004,  1, 0, 0, 32'hFFFFFFF5, 32'h0,        4'h3, 32'h00000004, 4'b1000, 0);
        step("add_zero",   0, 0, 0, 1, 0, 0, 1, 32'h00000000, 4'b0110, 32'h0,        4'h4, 32'h00000008,  1, 0, 0, 32'h0,        32'h0,        4'h4, 32'h00000008, 4'b0110, 1);
        step("add_nos",    0, 0, 0, 1, 0, 0, 0, 32'h00000002, 4'b0011, 32'h0,        4'h5, 32'h0000000C,  1, 0, 0, 32'h2,        32'h0,        4'h5, 32'h0000000C, 4'b0110, 1);
        step("str",        0, 0, 0, 0, 0, 1, 0, 32'h00000400, 4'b0000, 32'hDEADBEEF, 4'h2, 32'h00000010,  0, 0, 1, 32'h400,      32'hDEADBEEF, 4'h2, 32'h00000010, 4'b0110, 1);
        step("frz0",       0, 1, 0, 1, 1, 0, 1, 32'h00000800, 4'b1001, 32'h0,        4'h7, 32'h00000014,  0, 0, 1, 32'h400,      32'hDEADBEEF, 4'h2, 32'h00000010, 4'b0110, 1);
        step("frz1",       0, 1, 0, 1, 1, 0, 1, 32'h00000800, 4'b1001, 32'h0,        4'h7, 32'h00000014,  0, 0, 1, 32'h400,      32'hDEADBEEF, 4'h2, 32'h00000010, 4'b0110, 1);
        step("frz2",       0, 1, 0, 1, 1, 0, 1, 32'h00000800, 4'b1001, 32'h0,        4'h7, 32'h00000014,  0, 0, 1, 32'h400,      32'hDEADBEEF, 4'h2, 32'h00000010, 4'b0110, 1);
        step("ldr",        0, 0, 0, 1, 1, 0, 0, 32'h00000800, 4'b1001, 32'h0,        4'h7, 32'h00000014,  1, 1, 0, 32'h800,      32'h0,        4'h7, 32'h00000014, 4'b0110, 1);
        step("add_n",      0, 0, 0, 1, 0, 0, 1, 32'hFFFFFFF0, 4'b1000, 32'h0,        4'h1, 32'h00000018,  1, 0, 0, 32'hFFFFFFF0, 32'h0,        4'h1, 32'h00000018, 4'b1000, 0);
        step("cmp_flush",  0, 0, 1, 0, 0, 0, 1, 32'h00000005, 4'b0110, 32'h0,        4'h0, 32'h0000001C,  0, 0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        4'b1000, 0);
        step("cmp",        0, 0, 0, 0, 0, 0, 1, 32'h00000005, 4'b0110, 32'h0,        4'h0, 32'h0000001C,  0, 0, 0, 32'h5,        32'h0,        4'h0, 32'h0000001C, 4'b0110, 1);
        step("frz_flush",  0, 1, 1, 1, 0, 0, 1, 32'h00000077, 4'b1001, 32'h0,        4'h9, 32'h00000020,  0, 0, 0, 32'h5,        32'h0,        4'h0, 32'h0000001C, 4'b0110, 1);
        step("rst_all",    1, 1, 1, 1, 0, 0, 1, 32'h00000077, 4'b1001, 32'h0,        4'h9, 32'h00000020,  0, 0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        4'b0000, 0);
        step("illegal",    0, 0, 0, 0, 1, 1, 1, 32'h00000123, 4'b0010, 32'h0000CAFE, 4'h8, 32'h00000024,  0, 1, 1, 32'h123,      32'hCAFE,     4'h8, 32'h00000024, 4'b0010, 1);
        step("adc",        0, 0, 0, 1, 0, 0, 0, 32'h00000009, 4'b0000, 32'h0,        4'hA, 32'h00000028,  1, 0, 0, 32'h9,        32'h0,        4'hA, 32'h00000028, 4'b0010, 1);
        step("idle",       0, 0, 0, 0, 0, 0, 0, 32'h00000000, 4'b1111, 32'h0,        4'h0, 32'h00000000,  0, 0, 0, 32'h0,        32'h0,        4'h0, 32'h0,        4'b0010, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exe_mem_stage_reg.md
Name: exe_mem_stage_reg

Overview:
- Pipeline register between the EXE stage (ALU plus Val2 generator) and the MEM stage of the ARM core.
- Captures the ALU result, store data, destination register and memory/write-back controls each cycle.
- Also owns the architectural NZCV status register. That register is written from the ALU status when the instruction's S bit is set, and it feeds carry_in back to the ALU and to the condition-check logic.
- Supports stall (freeze) and bubble insertion (flush) driven by the hazard unit.

Parameters:
- DATA_W, 32, width of alu_res, val_rm and pc paths
- REG_ADDR_W, 4, width of destination register index (R0-R15)

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- freeze  in  1  hold all state (MEM stall)
- flush  in  1  insert bubble: capture a null instruction instead of the EXE outputs
- wb_en_in  in  1  write-back enable from EXE
- mem_r_en_in  in  1  load enable from EXE
- mem_w_en_in  in  1  store enable from EXE
- s_in  in  1  S bit: update status register
- alu_res_in  in  DATA_W  ALU result (address for LDR/STR)
- status_in  in  4  ALU flags {N,Z,C,V} = [3:0]
- val_rm_in  in  DATA_W  store data (Rd value for STR)
- dest_in  in  REG_ADDR_W  destination register
- pc_in  in  DATA_W  PC+4 of the instruction, for debug/trace
- wb_en  out  1  registered wb_en
- mem_r_en  out  1  registered load enable
- mem_w_en  out  1  registered store enable
- alu_res  out  DATA_W  registered ALU result
- val_rm  out  DATA_W  registered store data
- dest  out  REG_ADDR_W  registered destination
- pc  out  DATA_W  registered PC
- status_reg  out  4  architectural NZCV {N,Z,C,V}
- carry_out  out  1  status_reg[1], wired to ALU carry_in

Behaviour:
- Priority each rising edge: rst > freeze > flush > normal load.
- rst=1: every output register is 0, including status_reg=4'b0000. rst overrides freeze and flush; it takes effect in the cycle it is sampled, including mid-stall.
- freeze=1 (rst=0): all pipeline fields and status_reg hold their values. flush is ignored while freeze=1, and a flush asserted only during freeze is lost. The hazard unit keeps flush high until freeze drops.
- flush=1, freeze=0:
  - wb_en, mem_r_en and mem_w_en load 0.
  - alu_res, val_rm, dest and pc load 0.
  - status_reg holds; the S bit is suppressed.
- Normal load: every field loads its _in value one cycle after presentation (latency 1). When s_in=1, status_reg <= status_in in the same edge.
- status_reg changes only on a normal load with s_in=1. CMP and TST arrive with s_in=1 and wb_en_in=0 and still update the flags.
- carry_out is combinational from status_reg, so no extra cycle. An ADC or SBC issued in the cycle after an S-setting instruction sees the new C.
- mem_r_en_in and mem_w_en_in both high is illegal. The block captures both unchanged and does not arbitrate; the bench flags it.
- No arithmetic is done in the block; widths pass through unchanged.

Test Plan:
- rst=1 for 2 cycles with nonzero inputs and freeze=1 -> all outputs 0, status_reg=4'b0000.
- ADD 10 + -21: alu_res_in=32'hFFFFFFF5, status_in=4'b1000, s_in=1, wb_en_in=1, dest_in=3 -> next cycle:
  - alu_res=32'hFFFFFFF5, dest=3, wb_en=1
  - status_reg=4'b1000, carry_out=0
- ADD -10 + 10 with s_in=1, status_in=4'b0110 -> status_reg=4'b0110, carry_out=1. Follow with ADD -2147483647 + -2147483647: alu_res_in=32'h00000002, status_in=4'b0011, s_in=0 -> alu_res=2, status_reg stays 4'b0110.
- STR: alu_res_in=32'h00000400, val_rm_in=32'hDEADBEEF, mem_w_en_in=1; freeze=1 for 3 cycles while inputs change to an LDR -> outputs hold the STR fields for all 3 cycles, then load the LDR on the first cycle with freeze=0.
- Flush: flush=1 with CMP inputs (s_in=1, status_in=4'b0110, wb_en_in=0) over status_reg=4'b1000 -> all enables 0, alu_res=0, status_reg stays 4'b1000. The same CMP without flush -> status_reg=4'b0110.
- Simultaneous events: freeze=1 and flush=1 together -> hold; rst=1 with freeze=1 and flush=1 -> all outputs 0.
